// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle rx_valid / frame_err pulses and a held copy of the last good byte.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    // state        | meaning
    // ST_IDLE      | line idle, waiting for a falling edge on rx_s
    // ST_START     | half a bit in, confirm the start bit is still low
    // ST_DATA      | sample 8 data bits at mid-bit, LSB first
    // ST_STOP      | sample stop bit at mid-bit, publish byte or flag error
    // ST_WAIT_HIGH | framing error seen, wait for the line to return high
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= 16'd0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == HALF_TC) begin
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                        // a start bit that is already high again was a glitch
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt            <= 16'd0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    // leaving at mid-stop-bit leaves room to catch a back-to-back start
                    if (cnt == BIT_TC) begin
                        cnt <= 16'd0;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    cnt <= 16'd0;
                    if (rx_s) state <= ST_IDLE;
                end
                default: begin
                    cnt   <= 16'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit: table of frames,
// hand-written corner sequences, and random frames against a byte-queue model.
module tb_uart_rx_byte;
    localparam int C = 16;
    localparam int LAT = C / 2 + 9 * C + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t       vecs[6];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         fall_cycle = 0;
    int         obs_valid = 0;
    int         obs_err = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed 0x%0h", name, act);
    endtask

    // Model: each good frame queues its byte; each rx_valid must deliver the next one.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && frame_err) fail("valid_and_err_together", 32'd1);
            if (rx_valid && prev_valid) fail("valid_pulse_too_long", 32'd2);
            if (rx_valid) begin
                n_tests++;
                if ((cyc - fall_cycle) < LAT - 1 || (cyc - fall_cycle) > LAT + 1) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, expected %0d +/-1", cyc - fall_cycle, LAT);
                end
                if (exp_q.size() == 0) fail("unexpected_rx_valid", {24'd0, rx_data});
                else check("rx_data_sequence", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                obs_valid <= obs_valid + 1;
            end
            if (frame_err) obs_err <= obs_err + 1;
        end
        prev_valid <= rx_valid & ~reset;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
        if (stop) exp_q.push_back(d);
        rx = 1'b0;
        fall_cycle = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        if (!stop) repeat (hold_low) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'h00);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         bv;
        int         be;
        int         want_v;
        int         want_e;
        logic [7:0] last_good;
        logic [7:0] abort_byte;
        logic [7:0] d;
        logic       stop;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
        vecs[2] = '{8'h81, 1'b1, 8'h81, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1, 0};

        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 6; i++) begin
            bv = obs_valid;
            be = obs_err;
            send_frame(vecs[i].data, vecs[i].stop, 0);
            idle(20);
            check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_valid_count", i), obs_valid - bv, vecs[i].exp_valid);
            check($sformatf("vec%0d_err_count", i), obs_err - be, vecs[i].exp_err);
        end

        // short low glitch must be rejected as a false start
        bv = obs_valid;
        be = obs_err;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_dropped", {31'd0, busy}, 32'd0);
        idle(10);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h5A);
        check("glitch_valid_count", obs_valid - bv, 32'd0);
        check("glitch_err_count", obs_err - be, 32'd0);

        // bad stop bit followed by a long break, then a good frame
        bv = obs_valid;
        be = obs_err;
        send_frame(8'h3C, 1'b0, 100);
        check("break_err_count", obs_err - be, 32'd1);
        check("break_valid_count", obs_valid - bv, 32'd0);
        check("break_rx_data_held", {24'd0, rx_data}, 32'h5A);
        idle(10);
        send_frame(8'h81, 1'b1, 0);
        idle(20);
        check("after_break_rx_data", {24'd0, rx_data}, 32'h81);
        check("after_break_valid_count", obs_valid - bv, 32'd1);
        check("after_break_err_count", obs_err - be, 32'd1);

        // back-to-back frames with no idle gap
        bv = obs_valid;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(20);
        check("b2b_valid_count", obs_valid - bv, 32'd2);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

        // reset in the middle of bit 4 of 0x5A
        bv = obs_valid;
        be = obs_err;
        abort_byte = 8'h5A;
        rx = 1'b0;
        fall_cycle = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            repeat (C) @(negedge clk);
        end
        rx = abort_byte[4];
        repeat (C / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_reset("midframe_reset");
        reset = 1'b0;
        idle(C * 6);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid_count", obs_valid - bv, 32'd0);
        check("abort_err_count", obs_err - be, 32'd0);
        send_frame(8'h12, 1'b1, 0);
        idle(20);
        check("post_reset_rx_data", {24'd0, rx_data}, 32'h12);

        // random frames: occasional framing errors, random gaps including zero
        last_good = 8'h12;
        bv = obs_valid;
        be = obs_err;
        want_v = 0;
        want_e = 0;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, stop, int'($urandom_range(0, 30)));
            if (stop) begin
                want_v++;
                last_good = d;
                idle(int'($urandom_range(0, 12)));
            end else begin
                want_e++;
                idle(int'($urandom_range(4, 12)));
            end
        end
        idle(20);
        check("rand_valid_count", obs_valid - bv, want_v);
        check("rand_err_count", obs_err - be, want_e);
        check("rand_rx_data", {24'd0, rx_data}, {24'd0, last_good});
        check("rand_queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
